// File: rtl/reg_file.sv
// ----------------------------------------------------------------------------
// reg_file
//   Register file feeding the datapath logic units (XOR, AND, adder, shifter).
//   Two combinational read ports supply operands A and B. One synchronous
//   write port takes the ALU/memory result at the end of the cycle. Because
//   the reads are combinational, a single-cycle datapath can read, compute
//   and write back within one clock.
//
// Parameters
//   DATA_WIDTH : width of each register and of every data port
//   ADDR_WIDTH : register index width, depth = 2**ADDR_WIDTH
//   ZERO_REG   : 1 -> register 0 reads as 0 and ignores writes
//   BYPASS     : 1 -> a read of the register being written in the same cycle
//                     returns wr_data (write-through)
//
// Ports
//   clk        : datapath clock, all state changes on the rising edge
//   rst        : synchronous active-low reset
//   rd_addr_a  : operand A read index      rd_data_a : operand A
//   rd_addr_b  : operand B read index      rd_data_b : operand B
//   wr_en      : write enable
//   wr_addr    : write index
//   wr_data    : write data
//   wr_done    : one-cycle pulse after each accepted write
//
// Write handshake: a write is accepted at a rising edge when rst=1, wr_en=1
// and (ZERO_REG=0 or wr_addr!=0). There is no back-pressure; the port is
// always ready. wr_done is high in exactly the cycle after each accepted
// write, so back-to-back accepted writes keep it high continuously.
// ----------------------------------------------------------------------------
module reg_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter bit ZERO_REG   = 1'b0,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic [DATA_WIDTH-1:0] rd_data_a,
    output logic [DATA_WIDTH-1:0] rd_data_b,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_done
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic                  wr_done_q;
    logic                  wr_done_d;
    logic                  wr_accept;

    // A write presented during reset is dropped, and with ZERO_REG the
    // hard-wired zero register never takes a write.
    assign wr_accept = rst && wr_en && !(ZERO_REG && (wr_addr == '0));

    always_comb begin
        mem_d     = mem_q;
        wr_done_d = wr_accept;
        if (wr_accept) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_done_q <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            wr_done_q <= wr_done_d;
        end
    end

    // Read ports. The bypass keys off wr_accept, so nothing is forwarded
    // during reset or for a rejected write to register 0. The zero-register
    // override comes last so register 0 reads 0 even before the first reset.
    always_comb begin
        rd_data_a = mem_q[rd_addr_a];
        if (BYPASS && wr_accept && (wr_addr == rd_addr_a)) begin
            rd_data_a = wr_data;
        end
        if (ZERO_REG && (rd_addr_a == '0)) begin
            rd_data_a = '0;
        end
    end

    always_comb begin
        rd_data_b = mem_q[rd_addr_b];
        if (BYPASS && wr_accept && (wr_addr == rd_addr_b)) begin
            rd_data_b = wr_data;
        end
        if (ZERO_REG && (rd_addr_b == '0)) begin
            rd_data_b = '0;
        end
    end

    assign wr_done = wr_done_q;

endmodule

// File: tb/tb_reg_file.sv
// ----------------------------------------------------------------------------
// tb_reg_file
//   Four reg_file instances share one stimulus stream, one per combination of
//   ZERO_REG (cfg bit 1) and BYPASS (cfg bit 0). The driver issues one
//   operation per cycle, computes the expected outputs of every instance from
//   a behavioural model and queues them; the monitor samples the outputs on
//   the falling edge (before the write lands) and compares against the queue.
// ----------------------------------------------------------------------------
module tb_reg_file;

    localparam int NCFG = 4;
    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NREG = 32;

    typedef struct packed {
        logic [NCFG-1:0][DW-1:0] a;
        logic [NCFG-1:0][DW-1:0] b;
        logic [NCFG-1:0]         done;
    } exp_t;

    localparam int EXP_W = $bits(exp_t);

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] rd_addr_a;
    logic [AW-1:0] rd_addr_b;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    logic [DW-1:0] rd_a    [NCFG];
    logic [DW-1:0] rd_b    [NCFG];
    logic          done_o  [NCFG];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        reg_file #(
            .DATA_WIDTH(DW),
            .ADDR_WIDTH(AW),
            .ZERO_REG  ((g / 2) == 1),
            .BYPASS    ((g % 2) == 1)
        ) dut (
            .clk      (clk),
            .rst      (rst),
            .rd_addr_a(rd_addr_a),
            .rd_addr_b(rd_addr_b),
            .rd_data_a(rd_a[g]),
            .rd_data_b(rd_b[g]),
            .wr_en    (wr_en),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .wr_done  (done_o[g])
        );
    end

    // ---------------- reference model ----------------
    logic [DW-1:0] mdl [NCFG][NREG];
    bit            prev_acc [NCFG];

    function automatic logic [DW-1:0] model_read(input int g, input logic [AW-1:0] ra,
                                                 input bit acc, input logic [AW-1:0] wa,
                                                 input logic [DW-1:0] wd);
        bit zr;
        bit bp;
        zr = (g / 2) == 1;
        bp = (g % 2) == 1;
        if (zr && ra == 0)               return '0;
        if (bp && acc && wa == ra)       return wd;
        return mdl[g][ra];
    endfunction

    // ---------------- scoreboard ----------------
    logic [EXP_W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    function automatic void check(input string name, input int g,
                                  input logic [DW-1:0] got, input logic [DW-1:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s cfg%0d t=%0t: got %h expected %h", name, g, $time, got, want);
        end
    endfunction

    // ---------------- driver ----------------
    task automatic step(input bit r, input bit we, input logic [AW-1:0] wa,
                        input logic [DW-1:0] wd, input logic [AW-1:0] ra,
                        input logic [AW-1:0] rb);
        exp_t e;
        bit   acc [NCFG];
        @(posedge clk);
        #1;
        rst       = r;
        wr_en     = we;
        wr_addr   = wa;
        wr_data   = wd;
        rd_addr_a = ra;
        rd_addr_b = rb;
        for (int g = 0; g < NCFG; g++) begin
            acc[g]    = r && we && !(((g / 2) == 1) && wa == 0);
            e.a[g]    = model_read(g, ra, acc[g], wa, wd);
            e.b[g]    = model_read(g, rb, acc[g], wa, wd);
            e.done[g] = prev_acc[g];
        end
        exp_q.push_back(e);
        // Apply the edge that ends this cycle.
        for (int g = 0; g < NCFG; g++) begin
            if (!r) begin
                for (int k = 0; k < NREG; k++) mdl[g][k] = '0;
            end else if (acc[g]) begin
                mdl[g][wa] = wd;
            end
            prev_acc[g] = acc[g];
        end
    endtask

    // ---------------- monitor ----------------
    exp_t m_e;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            m_e = exp_q.pop_front();
            for (int g = 0; g < NCFG; g++) begin
                check("rd_data_a", g, rd_a[g], m_e.a[g]);
                check("rd_data_b", g, rd_b[g], m_e.b[g]);
                check("wr_done",   g, {31'b0, done_o[g]}, {31'b0, m_e.done[g]});
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [AW-1:0] wa;
        logic [AW-1:0] ra;
        logic [AW-1:0] rb;
        rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr_a = '0; rd_addr_b = '0;
        for (int g = 0; g < NCFG; g++) begin
            prev_acc[g] = 1'b0;
            for (int k = 0; k < NREG; k++) mdl[g][k] = '0;
        end
        repeat (2) @(posedge clk);

        // Reset state, then reset clearing a written register.
        step(0, 0, 0, 0, 5, 5);
        step(1, 1, 5, 32'hFFFF_FFFF, 5, 5);
        step(1, 0, 0, 0, 5, 5);
        step(0, 0, 0, 0, 5, 5);
        step(1, 0, 0, 0, 5, 5);

        // XOR operands.
        step(1, 1, 1, 32'd1000000007, 1, 2);
        step(1, 0, 0, 0, 1, 2);
        step(1, 1, 2, 32'd143, 1, 2);
        step(1, 0, 0, 0, 1, 2);
        step(1, 0, 0, 0, 1, 2);

        // Same-cycle collision on both ports, then the value after the edge.
        step(1, 1, 3, 32'd1000245, 3, 3);
        step(1, 0, 0, 0, 3, 3);

        // Register 0 write.
        step(1, 1, 0, 32'd134422, 0, 0);
        step(1, 0, 0, 0, 0, 0);

        // Ignored writes: disabled, then during reset.
        step(1, 0, 7, 32'd145457, 7, 7);
        step(1, 0, 0, 0, 7, 7);
        step(0, 1, 7, 32'd145457, 7, 7);
        step(1, 0, 0, 0, 7, 7);
        step(1, 1, 7, 32'd145457, 7, 0);
        step(1, 0, 0, 0, 7, 7);

        // Dual-port same address.
        step(1, 1, 9, 32'd324521, 0, 1);
        step(1, 0, 0, 0, 9, 9);

        // Sweep: back-to-back writes, then read-back on both ports.
        for (int i = 0; i < NREG; i++) begin
            step(1, 1, AW'(i), DW'(i * 4097), AW'(i), AW'((i + 31) % NREG));
        end
        for (int i = 0; i < NREG; i++) begin
            step(1, 0, 0, 0, AW'(i), AW'(NREG - 1 - i));
        end

        // Random traffic with frequent collisions and occasional reset.
        for (int n = 0; n < 600; n++) begin
            wa = AW'($urandom_range(0, NREG - 1));
            ra = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, NREG - 1));
            rb = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, NREG - 1));
            step(($urandom_range(0, 39) != 0), ($urandom_range(0, 9) < 7), wa, $urandom(), ra, rb);
        end
        step(1, 0, 0, 0, 0, 0);

        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- 32-entry x 32-bit register file that sits directly upstream of the datapath logic units (XOR, AND, adder, shifter).
- Two read ports drive operand buses A and B straight into the logic-unit inputs. One write port accepts the ALU/memory result at the end of the instruction cycle.
- Reads are combinational so a single-cycle datapath can read, compute and write back in one clock.

Parameters:
- DATA_WIDTH, 32, width of each register and of all data ports.
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH.
- ZERO_REG, 0, when 1 register 0 reads as 0 and ignores writes; when 0 register 0 is an ordinary register.
- BYPASS, 1, when 1 a read of the register being written in the same cycle returns the write data (write-through); when 0 it returns the old stored value.

Ports:
- clk  input  1  datapath clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- rd_addr_a  input  ADDR_WIDTH  read index for operand A.
- rd_addr_b  input  ADDR_WIDTH  read index for operand B.
- rd_data_a  output  DATA_WIDTH  operand A, feeds logic-unit input A.
- rd_data_b  output  DATA_WIDTH  operand B, feeds logic-unit input B.
- wr_en  input  1  write enable.
- wr_addr  input  ADDR_WIDTH  write index.
- wr_data  input  DATA_WIDTH  write data (ALU/memory result).
- wr_done  output  1  registered pulse: high for exactly one cycle after an accepted write.

Behaviour:
- Reset:
  - rst=0 at a rising edge clears every register to 0 and clears wr_done to 0.
  - wr_en is ignored in a reset cycle.
  - The reset action takes priority over any write presented in the same cycle.
- Write:
  - At a rising edge with rst=1 and wr_en=1, the register at wr_addr takes wr_data.
  - A write is not accepted when wr_en=0.
  - When ZERO_REG=1 and wr_addr=0, the write is not accepted either; the storage is unchanged and wr_done is not pulsed.
- wr_done:
  - Equals 1 in the cycle following an accepted write, else 0.
  - Back-to-back accepted writes hold wr_done high continuously.
- Read:
  - Purely combinational: rd_data_x = reg[rd_addr_x]; no latency.
  - With ZERO_REG=1, address 0 always reads 0.
- Same-cycle read/write collision (rd_addr_x == wr_addr, wr_en=1, rst=1, and the write is accepted):
  - BYPASS=1: rd_data_x = wr_data, combinationally, before the edge.
  - BYPASS=0: rd_data_x = the stored (old) value; the new value is visible after the edge.
  - Ports A and B resolve the collision independently; both may hit the same address.
- Bypass during reset: with BYPASS=1 and rst=0, no bypass occurs; reads return stored contents, which are 0 after the edge.
- Reset mid-operation: a write presented in the same cycle as rst=0 is lost. The next write after rst returns to 1 behaves normally.
- Width rules:
  - No truncation or extension anywhere.
  - Address space fully decoded (2**ADDR_WIDTH entries); no out-of-range handling needed.
- No X on outputs after the first reset edge.

Test Plan:
- Reset clear: write 32'hFFFF_FFFF to r5, assert rst=0 for one edge -> rd_addr_a=5 reads 0; wr_done=0.
- Write/read for XOR operands:
  - Write r1=1000000007, then r2=143.
  - Read a=1, b=2 -> rd_data_a=1000000007, rd_data_b=143.
  - wr_done is high for one cycle after each write.
- Bypass (BYPASS=1):
  - Hold rd_addr_a=3, drive wr_en=1, wr_addr=3, wr_data=1000245.
  - Before the edge, rd_data_a=1000245; after the edge, it stays 1000245.
  - Repeat with BYPASS=0 -> 0 before the edge, 1000245 after.
- Zero register (ZERO_REG=1): write r0=134422 -> r0 reads 0, wr_done stays 0. With ZERO_REG=0 -> r0 reads 134422.
- Write ignored:
  - wr_en=0 with wr_addr=7, wr_data=145457 -> r7 unchanged (0).
  - Same write in a cycle with rst=0 -> r7 is 0 after the edge and wr_done=0.
- Dual-port same address: write r9=324521, then rd_addr_a=rd_addr_b=9 -> both outputs 324521. Sweep all 32 addresses with value = index*4097 and check read-back on both ports.
